// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge: turns a valid/ready command port into single AXI-Lite
// write or read transactions and returns one response per command.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/wdata  command port (one command in flight)
//   rsp_valid/ready/write/rdata/resp  response port (rdata is 0 for writes)
//   m_axi_aw*/w*/b*                   AXI-Lite write channels
//   m_axi_ar*/r*                      AXI-Lite read channels
module axi_lite_master_bridge #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic              m_axi_bvalid,
    input  logic [1:0]        m_axi_bresp,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);
    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;
    state_t state;
    logic aw_done, w_done, aw_now, w_now;
    // A channel counts as done if it finished earlier or handshakes at this edge.
    always_comb begin
        aw_now = aw_done | (m_axi_awvalid & m_axi_awready);
        w_now  = w_done | (m_axi_wvalid & m_axi_wready);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid && cmd_ready) begin
                    cmd_ready <= 1'b0;
                    aw_done   <= 1'b0;
                    w_done    <= 1'b0;
                    if (cmd_write) begin
                        m_axi_awaddr  <= cmd_addr;
                        m_axi_wdata   <= cmd_wdata;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        state         <= WR;
                    end else begin
                        m_axi_araddr  <= cmd_addr;
                        m_axi_arvalid <= 1'b1;
                        state         <= RD_AR;
                    end
                end
                WR: begin
                    // Each valid drops on its own handshake; a dropped valid stays low.
                    aw_done <= aw_now;
                    w_done  <= w_now;
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready) m_axi_wvalid <= 1'b0;
                    if (aw_now && w_now) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_B;
                    end
                end
                WR_B: if (m_axi_bvalid) begin
                    m_axi_bready <= 1'b0;
                    rsp_resp     <= m_axi_bresp;
                    rsp_rdata    <= '0;
                    rsp_write    <= 1'b1;
                    rsp_valid    <= 1'b1;
                    state        <= RSP;
                end
                RD_AR: if (m_axi_arready) begin
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b1;
                    state         <= RD_R;
                end
                RD_R: if (m_axi_rvalid) begin
                    m_axi_rready <= 1'b0;
                    rsp_resp     <= m_axi_rresp;
                    rsp_rdata    <= m_axi_rdata;
                    rsp_write    <= 1'b0;
                    rsp_valid    <= 1'b1;
                    state        <= RSP;
                end
                RSP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// tb_axi_lite_master_bridge: directed scoreboard bench with a register-file AXI-Lite slave model.
module tb_axi_lite_master_bridge;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    axi_lite_master_bridge #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    // Slave model: registers at 0x00..0x10, word-aligned; anything else gets SLVERR.
    logic [31:0] mem [8] = '{32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    int aw_delay = 0, w_delay = 0, ar_delay = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    int aw_hs = 0, w_hs = 0, ar_hs = 0, r_hs = 0, b_hs = 0;
    int aw_hi = 0, w_hi = 0, ar_hi = 0, unstable = 0, bready_early = 0;
    logic        aw_got = 1'b0, w_got = 1'b0, aw_prev = 1'b0, ar_prev = 1'b0;
    logic [31:0] sl_awa = '0, sl_wd = '0, aw_prev_a = '0, ar_prev_a = '0;

    assign m_axi_awready = aw_cnt >= aw_delay;
    assign m_axi_wready  = w_cnt >= w_delay;
    assign m_axi_arready = ar_cnt >= ar_delay;

    function automatic logic ok(input logic [31:0] a);
        return a[1:0] == 2'b00 && a <= 32'h10;
    endfunction

    always @(posedge clk) begin
        aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
        w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
        ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
        if (m_axi_awvalid && m_axi_awready) aw_hs <= aw_hs + 1;
        if (m_axi_wvalid && m_axi_wready) w_hs <= w_hs + 1;
        if (m_axi_arvalid && m_axi_arready) ar_hs <= ar_hs + 1;
        if (m_axi_rvalid && m_axi_rready) r_hs <= r_hs + 1;
        if (m_axi_bvalid && m_axi_bready) b_hs <= b_hs + 1;
        if (!rst_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; m_axi_bvalid <= 1'b0; m_axi_rvalid <= 1'b0;
            m_axi_bresp <= 2'b00; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin aw_got <= 1'b1; sl_awa <= m_axi_awaddr; end
            if (m_axi_wvalid && m_axi_wready) begin w_got <= 1'b1; sl_wd <= m_axi_wdata; end
            if (aw_got && w_got && !m_axi_bvalid) begin
                aw_got <= 1'b0; w_got <= 1'b0; m_axi_bvalid <= 1'b1;
                m_axi_bresp <= ok(sl_awa) ? 2'b00 : 2'b10;
                if (ok(sl_awa)) mem[sl_awa[4:2]] <= sl_wd;
            end
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rdata  <= ok(m_axi_araddr) ? mem[m_axi_araddr[4:2]] : 32'd0;
                m_axi_rresp  <= ok(m_axi_araddr) ? 2'b00 : 2'b10;
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
        end
    end

    // Protocol monitor: valid-high cycle counts, address stability, early bready.
    always @(posedge clk) begin
        if (m_axi_awvalid) aw_hi <= aw_hi + 1;
        if (m_axi_wvalid) w_hi <= w_hi + 1;
        if (m_axi_arvalid) ar_hi <= ar_hi + 1;
        if ((m_axi_awvalid && aw_prev && m_axi_awaddr != aw_prev_a) ||
            (m_axi_arvalid && ar_prev && m_axi_araddr != ar_prev_a)) unstable <= unstable + 1;
        if (m_axi_bready && (m_axi_awvalid || m_axi_wvalid)) bready_early <= bready_early + 1;
        aw_prev <= m_axi_awvalid; aw_prev_a <= m_axi_awaddr;
        ar_prev <= m_axi_arvalid; ar_prev_a <= m_axi_araddr;
    end

    typedef struct {logic w; logic [31:0] d; logic [1:0] r;} exp_t;
    exp_t sb[$];
    int passed = 0, fails = 0, total = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd_accept_in_time", n < 50, 1);
        chk("cmd_ready_low_after_accept", cmd_ready, 0);
    endtask

    task automatic get_rsp(input int hold);
        int n = 0;
        exp_t e;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        chk("rsp_valid_in_time", n < 50, 1);
        chk("scoreboard_depth", sb.size(), 1);
        if (sb.size() > 0) e = sb.pop_front();
        chk("rsp_write", rsp_write, e.w);
        chk("rsp_rdata", rsp_rdata, e.d);
        chk("rsp_resp", rsp_resp, e.r);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = i[0]; cmd_write = 1'b0; cmd_addr = '0;
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_rdata", rsp_rdata, e.d);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_dropped", rsp_valid, 0);
        chk("cmd_ready_restored", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int b_aw, b_w, b_ar, b_r, b_b, h_aw, h_w, h_ar;
        repeat (3) @(negedge clk);
        chk("reset_flags", {cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                            m_axi_arvalid, m_axi_rready, rsp_write}, 8'b1000_0000);
        chk("reset_aw_w", {m_axi_awaddr, m_axi_wdata}, 64'd0);
        chk("reset_ar_rsp", {m_axi_araddr, rsp_rdata}, 64'd0);
        chk("reset_resp", rsp_resp, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write CFG_M = 4, ready-always slave.
        b_aw = aw_hs; b_w = w_hs; h_aw = aw_hi;
        sb.push_back('{w: 1'b1, d: 32'd0, r: 2'b00});
        send(1'b1, 32'h08, 32'd4);
        chk("wr1_awvalid", m_axi_awvalid, 1);
        chk("wr1_awaddr", m_axi_awaddr, 32'h08);
        chk("wr1_wdata", m_axi_wdata, 32'd4);
        get_rsp(0);
        chk("wr1_aw_hs", aw_hs - b_aw, 1);
        chk("wr1_w_hs", w_hs - b_w, 1);
        chk("wr1_aw_cycles", aw_hi - h_aw, 1);
        chk("wr1_slave_addr", sl_awa, 32'h08);
        chk("wr1_cfg_m", mem[2], 32'd4);

        // Read CFG_M back with arready delayed 2 cycles.
        ar_delay = 2; b_ar = ar_hs; b_r = r_hs; h_ar = ar_hi;
        sb.push_back('{w: 1'b0, d: 32'd4, r: 2'b00});
        send(1'b0, 32'h08, 32'd0);
        chk("rd1_araddr", m_axi_araddr, 32'h08);
        get_rsp(0);
        chk("rd1_ar_hs", ar_hs - b_ar, 1);
        chk("rd1_r_hs", r_hs - b_r, 1);
        chk("rd1_ar_cycles", ar_hi - h_ar, 3);
        ar_delay = 0;

        // awready delayed 3 cycles, wready immediate.
        aw_delay = 3; b_b = b_hs; h_aw = aw_hi; h_w = w_hi;
        sb.push_back('{w: 1'b1, d: 32'd0, r: 2'b00});
        send(1'b1, 32'h0C, 32'd7);
        chk("wr2_awaddr", m_axi_awaddr, 32'h0C);
        get_rsp(0);
        chk("wr2_aw_cycles", aw_hi - h_aw, 4);
        chk("wr2_w_cycles", w_hi - h_w, 1);
        chk("wr2_b_hs", b_hs - b_b, 1);
        chk("wr2_cfg_k", mem[3], 32'd7);
        aw_delay = 0;

        // Error responses pass through, no retry.
        b_aw = aw_hs; b_ar = ar_hs;
        sb.push_back('{w: 1'b1, d: 32'd0, r: 2'b10});
        send(1'b1, 32'h0A, 32'd9);
        get_rsp(0);
        sb.push_back('{w: 1'b0, d: 32'd0, r: 2'b10});
        send(1'b0, 32'h0A, 32'd0);
        get_rsp(0);
        chk("err_aw_hs", aw_hs - b_aw, 1);
        chk("err_ar_hs", ar_hs - b_ar, 1);

        // STATUS read with the response held off 5 cycles and stray cmd_valid pulses.
        b_ar = ar_hs;
        sb.push_back('{w: 1'b0, d: 32'd1, r: 2'b00});
        send(1'b0, 32'h04, 32'd0);
        get_rsp(5);
        repeat (2) @(negedge clk);
        chk("hold_ar_hs", ar_hs - b_ar, 1);
        chk("hold_no_extra_cmd", cmd_ready, 1);

        // Reset while awvalid waits on awready.
        aw_delay = 1000;
        send(1'b1, 32'h10, 32'd3);
        @(negedge clk);
        chk("rst_awvalid_waiting", m_axi_awvalid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_flags", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, rsp_valid, cmd_ready}, 5'b00001);
        aw_delay = 0;
        repeat (3) @(negedge clk);
        chk("rst_no_response", rsp_valid, 0);
        sb.push_back('{w: 1'b1, d: 32'd0, r: 2'b00});
        send(1'b1, 32'h10, 32'd5);
        get_rsp(0);
        sb.push_back('{w: 1'b0, d: 32'd5, r: 2'b00});
        send(1'b0, 32'h10, 32'd0);
        get_rsp(0);

        chk("addr_stable", unstable, 0);
        chk("bready_after_aw_w", bready_early, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
